rsa_operand_streamer: RTL and testbench
=======================================

RSA_OPERAND_STREAMER -- requirements
Module: rsa_operand_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6: word-index width; frame length is 2**ADDR_WIDTH words (64 words, 4096 bits).
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  buffer write strobe.
REQ-006 wr_sel  input  2  target buffer: 0=m (ciphertext), 1=e (private exponent), 2=n (modulus), 3=ignored.
REQ-007 wr_addr  input  ADDR_WIDTH  word index; 0 is the least-significant word.
REQ-008 wr_data  input  DATA_WIDTH  word to store.
REQ-009 num_words  input  ADDR_WIDTH+1  programmed operand length in words; sampled at start; 0 or values above 64 mean 64.
REQ-010 start  input  1  single-cycle frame request.
REQ-011 busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  operand-check failure flag, valid while done is high.
REQ-014 startInput  output  1  word-valid strobe to the Montgomery exponentiator.
REQ-015 m_input, e_input, n_input  output  DATA_WIDTH each  streamed operand words.
REQ-016 word_idx  output  ADDR_WIDTH  index of the word currently presented.

Function
REQ-017 The block SHALL hold three internal buffers (m, e, n) of 2**ADDR_WIDTH words each.
REQ-018 A write SHALL be accepted only in IDLE with wr_sel<3; writes while busy SHALL be dropped.
REQ-019 The FSM SHALL implement IDLE, CHECK (present only when the configuration macro is defined), STREAM, and DONE.
REQ-020 In IDLE, start=1 SHALL latch num_words as len and enter STREAM, or CHECK when the macro is defined.
REQ-021 A start received outside IDLE SHALL be ignored.
REQ-022 In STREAM, the block SHALL emit exactly 64 consecutive cycles with startInput=1 and word_idx=0..63, least-significant word first.
REQ-023 In each STREAM cycle, the outputs SHALL carry buffer[word_idx] when word_idx<len and all-zero otherwise (zero padding).
REQ-024 All data outputs SHALL be registered.
REQ-025 The first startInput cycle SHALL occur 1 cycle after the start cycle, or 2 cycles when CHECK is present; there SHALL be no gaps in the stream.
REQ-026 After word 63, the FSM SHALL enter DONE for one cycle (done=1, startInput=0) and then return to IDLE.
REQ-027 In the start cycle, a simultaneous wr_en and start in IDLE SHALL commit the write, and the resulting frame SHALL use the new word.
REQ-028 Outside STREAM, startInput SHALL be 0 and m_input, e_input, n_input and word_idx SHALL be 0.
REQ-029 A back-to-back start in the same cycle as done SHALL be ignored; the FSM SHALL be back in IDLE one cycle later and accept start there.

Reset
REQ-030 A synchronous reset SHALL force IDLE and drive busy, done, err, startInput, word_idx, m_input, e_input and n_input to 0 in the next cycle.
REQ-031 A reset asserted mid-STREAM SHALL abort the frame immediately without a done pulse.
REQ-032 Reset SHALL NOT clear the buffer contents.
REQ-033 Reset SHALL take priority over start and wr_en.

Configuration
REQ-034 The macro RSA_OPERAND_CHECK_EN, when defined, SHALL add a one-cycle CHECK state that tests n buffer word 0 bit 0 (the Montgomery modulus must be odd).
REQ-035 With RSA_OPERAND_CHECK_EN defined and n word 0 bit 0 equal to 0, the block SHALL skip STREAM, pulse done with err=1, and emit no startInput.
REQ-036 With RSA_OPERAND_CHECK_EN defined and n word 0 bit 0 equal to 1, the block SHALL proceed to STREAM and report err=0.
REQ-037 Without RSA_OPERAND_CHECK_EN, CHECK SHALL be absent, err SHALL be constant 0, and start-to-first-word latency SHALL be 1 cycle.

Verification
REQ-038 Write m[0]=64'h5B32DD707D25FCB0, e[0]=64'h6E74641191D3CDF1, n[0]=64'hEAA06C6A1B82DFBB, with num_words=1, then start -> cycle+1: startInput=1, word_idx=0, those three words appear; words 1..63 are zero; done after 64 strobes.
REQ-039 Fill 16 words per buffer, num_words=16, start -> words 0..15 match the buffers, words 16..63 are zero, exactly 64 startInput cycles, busy is high throughout.
REQ-040 Assert reset at word_idx=20 -> next cycle all outputs are 0, no done pulse; a later start restreams the unchanged buffer contents.
REQ-041 Issue wr_en (m[0]=64'hEB961218698CF89E) in the same cycle as start -> stream word 0 of m_input is 64'hEB961218698CF89E; a write issued mid-stream has no effect on the stream.
REQ-042 With RSA_OPERAND_CHECK_EN defined and n[0]=64'hBEC76F3B194537FA (even), start -> done=1 and err=1 two cycles later, startInput never asserted.
REQ-043 With RSA_OPERAND_CHECK_EN defined, a second start while busy -> ignored, only 64 strobes in total, with a single done pulse.

Source files
------------

// File: rtl/rsa_operand_streamer.sv
// rsa_operand_streamer
//   Holds the three RSA operands (ciphertext m, private exponent e,
//   modulus n), each 2**ADDR_WIDTH words. On start it streams one word
//   of each operand per cycle, least-significant word first, to a
//   Montgomery exponentiator. Words at or above the programmed length
//   are sent as zero.
//
//   Optional feature macro: RSA_OPERAND_CHECK_EN
//     Adds a one-cycle CHECK state before the stream. If n word 0 is
//     even, the frame is rejected: done pulses with err=1 and no words
//     are streamed.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset (buffers keep contents)
//   wr_en        : buffer write strobe (accepted only while idle)
//   wr_sel       : 0=m, 1=e, 2=n, 3=ignored
//   wr_addr      : word index, 0 = least-significant word
//   wr_data      : word to store
//   num_words    : operand length in words; 0 or >2**ADDR_WIDTH means full
//   start        : single-cycle frame request (accepted only while idle)
//   busy         : frame in progress
//   done         : one-cycle completion pulse
//   err          : operand check failure, valid with done
//   startInput   : word-valid strobe
//   m_input      : streamed m word
//   e_input      : streamed e word
//   n_input      : streamed n word
//   word_idx     : index of the word currently presented
module rsa_operand_streamer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  startInput,
  output logic [DATA_WIDTH-1:0] m_input,
  output logic [DATA_WIDTH-1:0] e_input,
  output logic [DATA_WIDTH-1:0] n_input,
  output logic [ADDR_WIDTH-1:0] word_idx
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

`ifdef RSA_OPERAND_CHECK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_STREAM = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd2, S_DONE = 2'd3} state_t;
`endif

  state_t                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    start_input_q;
  logic [ADDR_WIDTH-1:0]   word_idx_q;
  logic [DATA_WIDTH-1:0]   m_q;
  logic [DATA_WIDTH-1:0]   e_q;
  logic [DATA_WIDTH-1:0]   n_q;
  logic [ADDR_WIDTH:0]     len_q;
`ifdef RSA_OPERAND_CHECK_EN
  logic                    err_q;
`endif

  logic [DATA_WIDTH-1:0]   m_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   e_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   n_mem [DEPTH];

  logic                    wr_ok_s;
  logic [ADDR_WIDTH-1:0]   rd_idx_s;
  logic                    rd_valid_s;
  logic [DATA_WIDTH-1:0]   rd_m_s;
  logic [DATA_WIDTH-1:0]   rd_e_s;
  logic [DATA_WIDTH-1:0]   rd_n_s;
  logic [ADDR_WIDTH:0]     len_s;

  // Fetch the next word to present, with write bypass and zero padding.
  always_comb begin
    wr_ok_s  = wr_en && (wr_sel != 2'd3) && (state_q == S_IDLE);
    // Outside STREAM the next word to load is always word 0.
    if (state_q == S_STREAM) begin
      rd_idx_s = word_idx_q + ADDR_WIDTH'(1);
    end else begin
      rd_idx_s = '0;
    end
    // Word 0 is always inside the frame since the length is at least 1.
    rd_valid_s = (rd_idx_s == '0) || ({1'b0, rd_idx_s} < len_q);
    rd_m_s = m_mem[rd_idx_s];
    rd_e_s = e_mem[rd_idx_s];
    rd_n_s = n_mem[rd_idx_s];
    // A write landing in the start cycle must already be visible in word 0.
    if (wr_ok_s && (wr_addr == rd_idx_s)) begin
      case (wr_sel)
        2'd0:    rd_m_s = wr_data;
        2'd1:    rd_e_s = wr_data;
        2'd2:    rd_n_s = wr_data;
        default: rd_m_s = m_mem[rd_idx_s];
      endcase
    end else begin
      rd_m_s = rd_m_s;
    end
    if (!rd_valid_s) begin
      rd_m_s = '0;
      rd_e_s = '0;
      rd_n_s = '0;
    end else begin
      rd_m_s = rd_m_s;
    end
    if ((num_words == '0) || (num_words > (ADDR_WIDTH+1)'(DEPTH))) begin
      len_s = (ADDR_WIDTH+1)'(DEPTH);
    end else begin
      len_s = num_words;
    end
  end

  // Operand buffers; not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok_s) begin
      case (wr_sel)
        2'd0:    m_mem[wr_addr] <= wr_data;
        2'd1:    e_mem[wr_addr] <= wr_data;
        2'd2:    n_mem[wr_addr] <= wr_data;
        default: ;
      endcase
    end
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_input_q <= 1'b0;
      word_idx_q    <= '0;
      m_q           <= '0;
      e_q           <= '0;
      n_q           <= '0;
      len_q         <= '0;
`ifdef RSA_OPERAND_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q  <= len_s;
            busy_q <= 1'b1;
`ifdef RSA_OPERAND_CHECK_EN
            state_q <= S_CHECK;
`else
            state_q       <= S_STREAM;
            start_input_q <= 1'b1;
            word_idx_q    <= '0;
            m_q           <= rd_m_s;
            e_q           <= rd_e_s;
            n_q           <= rd_n_s;
`endif
          end
        end
`ifdef RSA_OPERAND_CHECK_EN
        S_CHECK: begin
          // Montgomery reduction needs an odd modulus.
          if (n_mem[0][0]) begin
            state_q       <= S_STREAM;
            start_input_q <= 1'b1;
            word_idx_q    <= '0;
            m_q           <= rd_m_s;
            e_q           <= rd_e_s;
            n_q           <= rd_n_s;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
`endif
        S_STREAM: begin
          if (word_idx_q == LAST_IDX) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            start_input_q <= 1'b0;
            word_idx_q    <= '0;
            m_q           <= '0;
            e_q           <= '0;
            n_q           <= '0;
          end else begin
            word_idx_q <= rd_idx_s;
            m_q        <= rd_m_s;
            e_q        <= rd_e_s;
            n_q        <= rd_n_s;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
`ifdef RSA_OPERAND_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign startInput = start_input_q;
  assign word_idx   = word_idx_q;
  assign m_input    = m_q;
  assign e_input    = e_q;
  assign n_input    = n_q;
`ifdef RSA_OPERAND_CHECK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_operand_streamer.sv
// Directed self-checking bench for rsa_operand_streamer.
module tb_rsa_operand_streamer;

  localparam int DW = 64;
  localparam int AW = 6;
`ifdef RSA_OPERAND_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = 2'd0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   num_words = '0;
  logic          start = 1'b0;
  logic          busy, done, err, startInput;
  logic [DW-1:0] m_input, e_input, n_input;
  logic [AW-1:0] word_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ref_m [64];
  logic [DW-1:0] ref_e [64];
  logic [DW-1:0] ref_n [64];

  rsa_operand_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .num_words(num_words),
    .start(start), .busy(busy), .done(done), .err(err),
    .startInput(startInput), .m_input(m_input), .e_input(e_input),
    .n_input(n_input), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    case (sel)
      2'd0: ref_m[addr] = d;
      2'd1: ref_e[addr] = d;
      2'd2: ref_n[addr] = d;
      default: ;
    endcase
  endtask

  // Pulse start (optionally with a write of m[0]); returns #1 after the accepting edge.
  task automatic kick(input logic [AW:0] nw, input bit w, input logic [DW-1:0] wd);
    @(posedge clk); #1;
    start = 1'b1; num_words = nw;
    if (w) begin
      wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = wd;
      ref_m[0] = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Follow one frame from the start edge to the done cycle; returns at the done sample.
  task automatic monitor(input int len, input bit extra_start, input bit mid_wr);
    int cyc = 0;
    int strobes = 0;
    int first = -1;
    bit fin = 1'b0;
    logic [DW-1:0] xm, xe, xn;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (done) begin
        fin = 1'b1;
        n_vec++;
        if (err !== 1'b0 || startInput !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL done_flags: err=%b startInput=%b busy=%b, required 0 0 0", err, startInput, busy);
        end
        n_vec++;
        if (word_idx !== '0 || m_input !== '0 || e_input !== '0 || n_input !== '0) begin
          n_err++;
          $display("FAIL done_zero: idx=%0d m=%h e=%h n=%h, required all zero", word_idx, m_input, e_input, n_input);
        end
      end else if (startInput) begin
        if (first < 0) first = cyc;
        xm = (strobes < len) ? ref_m[strobes] : '0;
        xe = (strobes < len) ? ref_e[strobes] : '0;
        xn = (strobes < len) ? ref_n[strobes] : '0;
        n_vec++;
        if (word_idx !== strobes[AW-1:0] || busy !== 1'b1) begin
          n_err++;
          $display("FAIL stream_idx: idx=%0d busy=%b, required idx=%0d busy=1", word_idx, busy, strobes);
        end
        n_vec++;
        if (m_input !== xm || e_input !== xe || n_input !== xn) begin
          n_err++;
          $display("FAIL stream_data[%0d]: m=%h e=%h n=%h, required m=%h e=%h n=%h",
                   strobes, m_input, e_input, n_input, xm, xe, xn);
        end
        strobes++;
        if (extra_start && strobes == 10) start = 1'b1;
        if (mid_wr && strobes == 3) begin
          wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 6'd5; wr_data = 64'hFFFF_0000_FFFF_0000;
        end
      end else begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL pre_stream_busy: busy=%b at cycle %0d, required 1", busy, cyc);
        end
      end
    end
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL done_timeout: no done within 200 cycles, required done");
    end
    n_vec++;
    if (strobes != 64 || first != LAT || cyc != LAT + 64) begin
      n_err++;
      $display("FAIL frame_shape: strobes=%0d first=%0d done_cyc=%0d, required 64 %0d %0d",
               strobes, first, cyc, LAT, LAT + 64);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || startInput !== 1'b0) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b startInput=%b, required 0 0 0", done, busy, startInput);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, done, err, startInput} !== 4'b0 || word_idx !== '0 ||
        m_input !== '0 || e_input !== '0 || n_input !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b err=%b si=%b idx=%0d, required all zero",
               busy, done, err, startInput, word_idx);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    wr(2'd0, 6'd0, 64'h5B32DD707D25FCB0);
    wr(2'd1, 6'd0, 64'h6E74641191D3CDF1);
    wr(2'd2, 6'd0, 64'hEAA06C6A1B82DFBB);
    kick(7'd1, 1'b0, '0);
    monitor(1, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_sixteen();
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 6'(i), {32'(i), 32'hA5A5_0000} ^ 64'h0123_4567_89AB_CDEF);
      wr(2'd1, 6'(i), {32'hC0DE_0000, 32'(i * 7)});
      wr(2'd2, 6'(i), {32'(i + 100), 32'h5555_AAAA} | 64'd1);
    end
    kick(7'd16, 1'b0, '0);
    monitor(16, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_full_len();
    for (int i = 16; i < 64; i++) begin
      wr(2'd0, 6'(i), {32'hF00D_0000, 32'(i)});
      wr(2'd1, 6'(i), {32'(i * 3), 32'h1234_5678});
      wr(2'd2, 6'(i), {32'h8000_0000, 32'(i << 4)});
    end
    kick(7'd0, 1'b0, '0);
    monitor(64, 1'b0, 1'b0);
    idle_check();
    kick(7'd100, 1'b0, '0);
    monitor(64, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_write_with_start();
    kick(7'd16, 1'b1, 64'hEB961218698CF89E);
    monitor(16, 1'b0, 1'b1);
    idle_check();
    kick(7'd16, 1'b0, '0);
    monitor(16, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_reset_mid_stream();
    bit hit = 1'b0;
    kick(7'd16, 1'b0, '0);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (startInput && word_idx == 6'd20) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_word20: word 20 not seen, required it");
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, err, startInput} !== 4'b0 || word_idx !== '0 ||
        m_input !== '0 || e_input !== '0 || n_input !== '0) begin
      n_err++;
      $display("FAIL abort_state: busy=%b done=%b si=%b idx=%0d m=%h, required all zero",
               busy, done, startInput, word_idx, m_input);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || startInput !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet: done=%b startInput=%b, required 0 0", done, startInput);
      end
    end
    kick(7'd16, 1'b0, '0);
    monitor(16, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_back_to_back();
    kick(7'd16, 1'b0, '0);
    monitor(16, 1'b1, 1'b0);
    // Start raised during the done cycle and held into the idle cycle.
    start = 1'b1;
    num_words = 7'd16;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || startInput !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done: busy=%b si=%b done=%b, required 0 0 0", busy, startInput, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    monitor(16, 1'b0, 1'b0);
    idle_check();
  endtask

`ifdef RSA_OPERAND_CHECK_EN
  task automatic test_check_even();
    logic [DW-1:0] keep;
    keep = ref_n[0];
    wr(2'd2, 6'd0, 64'hBEC76F3B194537FA);
    kick(7'd16, 1'b0, '0);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || startInput !== 1'b0) begin
      n_err++;
      $display("FAIL check_cycle: busy=%b done=%b si=%b, required 1 0 0", busy, done, startInput);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b1 || startInput !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL check_reject: done=%b err=%b si=%b busy=%b, required 1 1 0 0", done, err, startInput, busy);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || err !== 1'b0 || startInput !== 1'b0) begin
        n_err++;
        $display("FAIL check_after: done=%b err=%b si=%b, required 0 0 0", done, err, startInput);
      end
    end
    wr(2'd2, 6'd0, keep);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_sixteen();
    test_full_len();
    test_write_with_start();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef RSA_OPERAND_CHECK_EN
    test_check_even();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
